// File: rtl/alu_div_pkg.sv
// Shared types and constants for the 16-bit multi-cycle restoring divider.
package alu_div_pkg;

  localparam int unsigned DIV_WIDTH = 16;
  localparam int unsigned DIV_ITER  = 16;
  localparam int unsigned DIV_CNT_W = $clog2(DIV_ITER);

  localparam logic [DIV_WIDTH-1:0] DIV_DZ_QUOT  = 16'hFFFF;
  localparam logic [DIV_WIDTH-1:0] DIV_OVF_QUOT = 16'h8000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // Two's-complement negation, shared by operand magnitude and result fix-up.
  function automatic logic [DIV_WIDTH-1:0] div_neg(input logic [DIV_WIDTH-1:0] x);
    return (~x) + DIV_WIDTH'(1);
  endfunction

endpackage

// File: rtl/div_trial_sub17.sv
// Trial subtractor for one restoring step: diff = a - b via a + ~b + 1.
module div_trial_sub17 #(
  parameter int unsigned W = 17
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] diff_o,
  output logic         borrow_o
);

  assign diff_o   = a_i + (~b_i) + W'(1);
  // Partial remainder stays below 2*D, so the top bit is a clean borrow flag.
  assign borrow_o = diff_o[W-1];

endmodule

// File: rtl/alu_div_16bits.sv
// Multi-cycle restoring divider for DIV/DIVU (quotient -> LO, remainder -> HI).
// Define ALU_DIV_SIGNED_EN to build the signed path; otherwise all ops are unsigned.
module alu_div_16bits
  import alu_div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o,
  output logic             dz_o,
  output logic             v_o
);

  localparam int unsigned RW    = WIDTH + 1;
  localparam int unsigned CNT_W = DIV_CNT_W;
  localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(DIV_ITER - 1);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RW-1:0]    r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dz_pend_q, dz_pend_d;
  logic             ovf_pend_q, ovf_pend_d;

  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;
  logic             v_q, v_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] mag_x_c, mag_y_c;
  logic             neg_quot_c, neg_rem_c, ovf_c;
  logic [WIDTH-1:0] quot_fix_c, rem_fix_c;
  logic [RW-1:0]    r_shift_c, trial_c;
  logic             borrow_c;
  logic             unused_c;

  // Operand conditioning and result sign fix-up.
`ifdef ALU_DIV_SIGNED_EN
  assign neg_rem_c  = signed_i & dividend_i[WIDTH-1];
  assign neg_quot_c = signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
  assign mag_x_c    = (signed_i & dividend_i[WIDTH-1]) ? div_neg(dividend_i) : dividend_i;
  assign mag_y_c    = (signed_i & divisor_i[WIDTH-1])  ? div_neg(divisor_i)  : divisor_i;
  assign ovf_c      = signed_i & (dividend_i == WIDTH'(DIV_OVF_QUOT)) & (&divisor_i);
  assign quot_fix_c = neg_quot_q ? div_neg(q_q) : q_q;
  assign rem_fix_c  = neg_rem_q ? div_neg(r_q[WIDTH-1:0]) : r_q[WIDTH-1:0];
  assign unused_c   = r_q[WIDTH];
`else
  assign neg_rem_c  = 1'b0;
  assign neg_quot_c = 1'b0;
  assign mag_x_c    = dividend_i;
  assign mag_y_c    = divisor_i;
  assign ovf_c      = 1'b0;
  assign quot_fix_c = q_q;
  assign rem_fix_c  = r_q[WIDTH-1:0];
  assign unused_c   = r_q[WIDTH] ^ signed_i ^ neg_quot_q ^ neg_rem_q;
`endif

  assign r_shift_c = {r_q[WIDTH-1:0], q_q[WIDTH-1]};

  div_trial_sub17 #(
    .W (RW)
  ) u_trial (
    .a_i      (r_shift_c),
    .b_i      ({1'b0, d_q}),
    .diff_o   (trial_c),
    .borrow_o (borrow_c)
  );

  // Next-state, datapath and output-register update.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    r_d        = r_q;
    q_d        = q_q;
    d_d        = d_q;
    dvd_d      = dvd_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    dz_pend_d  = dz_pend_q;
    ovf_pend_d = ovf_pend_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    dz_d       = dz_q;
    v_d        = v_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d    = RUN;
          cnt_d      = '0;
          r_d        = '0;
          q_d        = mag_x_c;
          d_d        = mag_y_c;
          dvd_d      = dividend_i;
          neg_quot_d = neg_quot_c;
          neg_rem_d  = neg_rem_c;
          dz_pend_d  = (divisor_i == '0);
          ovf_pend_d = ovf_c;
          busy_d     = 1'b1;
        end
      end
      RUN: begin
        cnt_d  = cnt_q + CNT_W'(1);
        r_d    = borrow_c ? r_shift_c : trial_c;
        q_d    = {q_q[WIDTH-2:0], ~borrow_c};
        busy_d = 1'b1;
        if (cnt_q == ITER_LAST) begin
          state_d = FIX;
        end
      end
      FIX: begin
        state_d = DONE;
        done_d  = 1'b1;
        // Divide-by-zero wins over overflow; the two flags are exclusive.
        if (dz_pend_q) begin
          quot_d = WIDTH'(DIV_DZ_QUOT);
          rem_d  = dvd_q;
          dz_d   = 1'b1;
          v_d    = 1'b0;
        end else if (ovf_pend_q) begin
          quot_d = WIDTH'(DIV_OVF_QUOT);
          rem_d  = '0;
          dz_d   = 1'b0;
          v_d    = 1'b1;
        end else begin
          quot_d = quot_fix_c;
          rem_d  = rem_fix_c;
          dz_d   = 1'b0;
          v_d    = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      r_q        <= '0;
      q_q        <= '0;
      d_q        <= '0;
      dvd_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_pend_q  <= 1'b0;
      ovf_pend_q <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      dz_q       <= 1'b0;
      v_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      r_q        <= r_d;
      q_q        <= q_d;
      d_q        <= d_d;
      dvd_q      <= dvd_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      dz_pend_q  <= dz_pend_d;
      ovf_pend_q <= ovf_pend_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      dz_q       <= dz_d;
      v_q        <= v_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign quot_o = quot_q;
  assign rem_o  = rem_q;
  assign dz_o   = dz_q;
  assign v_o    = v_q;

endmodule

// File: tb/tb_alu_div_16bits.sv
// Scoreboard bench for alu_div_16bits: directed vectors, expectations queued at issue.
module tb_alu_div_16bits;

`ifdef ALU_DIV_SIGNED_EN
  localparam bit SG = 1'b1;
`else
  localparam bit SG = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic        signed_i;
  logic [15:0] dividend_i;
  logic [15:0] divisor_i;
  logic        busy_o;
  logic        done_o;
  logic [15:0] quot_o;
  logic [15:0] rem_o;
  logic        dz_o;
  logic        v_o;

  alu_div_16bits dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .signed_i   (signed_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .quot_o     (quot_o),
    .rem_o      (rem_o),
    .dz_o       (dz_o),
    .v_o        (v_o)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    logic        v;
    int          start_cyc;
  } exp_t;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic        s;
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    logic        v;
  } vec_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s id=%0d actual=0x%0h required=0x%0h", name, id, act, req);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops one expectation per done pulse.
  int          busy_cnt = 0;
  logic [15:0] last_q = '0, last_r = '0;
  logic        last_dz = 1'b0, last_v = 1'b0;
  logic [15:0] prev_q = '0, prev_r = '0;
  logic        prev_dz = 1'b0, prev_v = 1'b0;

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      busy_cnt = 0;
      last_q = '0; last_r = '0; last_dz = 1'b0; last_v = 1'b0;
    end else if (done_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", -1, 32'(done_o), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("quot", e.id, 32'(quot_o), 32'(e.q));
        chk("rem", e.id, 32'(rem_o), 32'(e.r));
        chk("dz", e.id, 32'(dz_o), 32'(e.dz));
        chk("v", e.id, 32'(v_o), 32'(e.v));
        chk("latency", e.id, 32'(cyc - e.start_cyc), 32'd18);
        chk("busy_cycles", e.id, 32'(busy_cnt), 32'd17);
        chk("busy_at_done", e.id, 32'(busy_o), 32'd0);
        chk("held_quot", e.id, 32'(prev_q), 32'(last_q));
        chk("held_rem", e.id, 32'(prev_r), 32'(last_r));
        chk("held_flags", e.id, 32'({prev_dz, prev_v}), 32'({last_dz, last_v}));
        last_q = e.q; last_r = e.r; last_dz = e.dz; last_v = e.v;
      end
      busy_cnt = 0;
    end else if (busy_o) begin
      busy_cnt++;
    end
    prev_q = quot_o; prev_r = rem_o; prev_dz = dz_o; prev_v = v_o;
  end

  // Drive a start at the current negedge; 'pre' edges are expected to ignore it.
  task automatic issue(input int id, input vec_t vc, input int pre);
    exp_t e;
    dividend_i = vc.x;
    divisor_i  = vc.y;
    signed_i   = vc.s;
    start_i    = 1'b1;
    e.id = id; e.q = vc.q; e.r = vc.r; e.dz = vc.dz; e.v = vc.v;
    e.start_cyc = cyc + pre;
    exp_q.push_back(e);
    repeat (pre + 1) @(negedge clk);
    start_i    = 1'b0;
    dividend_i = 16'($urandom);
    divisor_i  = 16'($urandom);
  endtask

  task automatic wait_done(input int id);
    int n;
    n = 0;
    while (!done_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", id, 32'(done_o), 32'd1);
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{16'd100,  16'd7,    1'b0, 16'h000E, 16'h0002, 1'b0, 1'b0};
    vecs[1] = '{16'hFF9C, 16'h0007, 1'b1, SG ? 16'hFFF2 : 16'h2484, SG ? 16'hFFFE : 16'h0000, 1'b0, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0};
    vecs[3] = '{16'h1234, 16'h0000, 1'b1, 16'hFFFF, 16'h1234, 1'b1, 1'b0};
    vecs[4] = '{16'h8000, 16'hFFFF, 1'b1, SG ? 16'h8000 : 16'h0000, SG ? 16'h0000 : 16'h8000, 1'b0, SG};
    vecs[5] = '{16'h0064, 16'hFFF9, 1'b1, SG ? 16'hFFF2 : 16'h0000, SG ? 16'h0002 : 16'h0064, 1'b0, 1'b0};
    vecs[6] = '{16'hFF9C, 16'hFFF9, 1'b1, SG ? 16'h000E : 16'h0000, SG ? 16'hFFFE : 16'hFF9C, 1'b0, 1'b0};
    vecs[7] = '{16'hFF9C, 16'h0000, 1'b1, 16'hFFFF, 16'hFF9C, 1'b1, 1'b0};
    vecs[8] = '{16'h0007, 16'h0064, 1'b0, 16'h0000, 16'h0007, 1'b0, 1'b0};
    vecs[9] = '{16'h8000, 16'hFFFF, 1'b0, 16'h0000, 16'h8000, 1'b0, 1'b0};

    rst_n = 1'b0; start_i = 1'b0; signed_i = 1'b0; dividend_i = '0; divisor_i = '0;
    repeat (3) @(negedge clk);
    chk("reset_quot", 0, 32'(quot_o), 32'd0);
    chk("reset_rem", 0, 32'(rem_o), 32'd0);
    chk("reset_ctrl", 0, 32'({busy_o, done_o, dz_o, v_o}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      issue(i + 1, vecs[i], 0);
      wait_done(i + 1);
      @(negedge clk);
    end

    // A start pulsed mid-run is dropped; one held across DONE is taken in IDLE.
    issue(11, '{16'd1000, 16'd33, 1'b0, 16'd30, 16'd10, 1'b0, 1'b0}, 0);
    repeat (4) @(negedge clk);
    dividend_i = 16'd9; divisor_i = 16'd3; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_done(11);
    issue(12, '{16'hABCD, 16'h0100, 1'b0, 16'h00AB, 16'h00CD, 1'b0, 1'b0}, 1);
    wait_done(12);
    @(negedge clk);

    // Asynchronous reset in the middle of a division.
    issue(13, '{16'd60000, 16'd7, 1'b0, 16'd8571, 16'd3, 1'b0, 1'b0}, 0);
    repeat (8) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_quot", 13, 32'(quot_o), 32'd0);
    chk("async_rst_rem", 13, 32'(rem_o), 32'd0);
    chk("async_rst_ctrl", 13, 32'({busy_o, done_o, dz_o, v_o}), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(14, '{16'd50, 16'd5, 1'b0, 16'd10, 16'd0, 1'b0, 1'b0}, 0);
    wait_done(14);
    repeat (3) @(negedge clk);

    chk("queue_empty", 0, 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time_ns=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
